// File: rtl/e_muldiv.sv
// Iterative HI/LO multiply/divide unit: 32-step radix-2 shift-add multiply
// and restoring divide, with MTHI/MTLO writes, flush abort and sign fix-up.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO are written directly from here
// RUN   | one multiply or divide step per edge, 32 steps in total
// FIX   | apply sign correction and write HI/LO, then return to IDLE
module e_muldiv (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_data_A,
   input  logic [31:0] i_data_B,
   input  logic [2:0]  i_con_MdCtrl,
   input  logic        i_con_Start,
   input  logic        i_con_Flush,
   output logic [31:0] o_data_Hi,
   output logic [31:0] o_data_Lo,
   output logic        o_con_Busy
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] acc_hi, acc_lo, op_b;
   logic        is_div, neg_q, neg_r, div_zero;

   logic        op_is_md, op_signed, op_div, accept, idle_req;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, div_shift;
   logic [33:0] div_diff;
   logic [63:0] prod, prod_fix;
   logic [31:0] fix_hi, fix_lo;

   // Request decode and operand magnitudes for the accept edge
   always_comb begin
      op_is_md  = (i_con_MdCtrl >= OP_MULT) && (i_con_MdCtrl <= OP_DIVU);
      op_signed = (i_con_MdCtrl == OP_MULT) || (i_con_MdCtrl == OP_DIV);
      op_div    = (i_con_MdCtrl == OP_DIV) || (i_con_MdCtrl == OP_DIVU);
      idle_req  = (state_q == ST_IDLE) && i_con_Start && !i_con_Flush;
      accept    = idle_req && op_is_md;
      mag_a     = (op_signed && i_data_A[31]) ? (32'd0 - i_data_A) : i_data_A;
      mag_b     = (op_signed && i_data_B[31]) ? (32'd0 - i_data_B) : i_data_B;
   end

   // One multiply step and one divide step, selected later by is_div
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : 33'd0);
      div_shift = {acc_hi, acc_lo[31]};
      div_diff  = {1'b0, div_shift} - {2'b00, op_b};
   end

   // Sign correction of the raw magnitude results
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = neg_q ? (64'd0 - prod) : prod;
      if (is_div) begin
         fix_hi = neg_r ? (32'd0 - acc_hi) : acc_hi;
         fix_lo = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_lo) : acc_lo);
      end else begin
         fix_hi = prod_fix[63:32];
         fix_lo = prod_fix[31:0];
      end
   end

   // Next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == 5'd31) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (i_con_Flush) state_d = ST_IDLE;
   end

   // State register and registered busy flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         o_con_Busy <= 1'b0;
      end else begin
         state_q    <= state_d;
         o_con_Busy <= (state_d != ST_IDLE);
      end
   end

   // Step counter; wraps 31 -> 0 at the end of RUN
   always_ff @(posedge i_clk) begin
      if (i_rst || i_con_Flush || accept) cnt_q <= 5'd0;
      else if (state_q == ST_RUN)         cnt_q <= cnt_q + 5'd1;
   end

   // Operand capture on accept, then the iterative shift datapath
   always_ff @(posedge i_clk) begin
      if (accept) begin
         op_b     <= mag_b;
         acc_hi   <= 32'd0;
         acc_lo   <= mag_a;
         is_div   <= op_div;
         neg_q    <= op_signed && (i_data_A[31] ^ i_data_B[31]);
         neg_r    <= op_signed && op_div && i_data_A[31];
         div_zero <= (i_data_B == 32'd0);
      end else if (state_q == ST_RUN) begin
         if (is_div) begin
            if (!div_diff[33]) begin
               acc_hi <= div_diff[31:0];
               acc_lo <= {acc_lo[30:0], 1'b1};
            end else begin
               acc_hi <= div_shift[31:0];
               acc_lo <= {acc_lo[30:0], 1'b0};
            end
         end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
         end
      end
   end

   // HI/LO: written by FIX or by MTHI/MTLO in IDLE; flush suppresses both
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_data_Hi <= 32'd0;
         o_data_Lo <= 32'd0;
      end else if (!i_con_Flush) begin
         if (state_q == ST_FIX) begin
            o_data_Hi <= fix_hi;
            o_data_Lo <= fix_lo;
         end else if (idle_req && (i_con_MdCtrl == OP_MTHI)) begin
            o_data_Hi <= i_data_A;
         end else if (idle_req && (i_con_MdCtrl == OP_MTLO)) begin
            o_data_Lo <= i_data_A;
         end
      end
   end

endmodule

// File: doc/e_muldiv.md
E_MULDIV -- requirements
Module: e_muldiv

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of i_clk.
REQ-002 i_clk  input  1  clock.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_data_A  input  32  operand A (rs), the same value as the ALU's A operand.
REQ-005 i_data_B  input  32  operand B (rt), the same value as the ALU's B operand.
REQ-006 i_con_MdCtrl  input  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none.
REQ-007 i_con_Start  input  1  one-cycle request qualifying i_con_MdCtrl.
REQ-008 i_con_Flush  input  1  abort an in-flight operation (exception or branch squash).
REQ-009 o_data_Hi  output  32  HI register.
REQ-010 o_data_Lo  output  32  LO register.
REQ-011 o_con_Busy  output  1  high while an operation is in flight; pipeline stalls MFHI/MFLO and new mul/div on it.

Function
REQ-012 States SHALL be IDLE, RUN and FIX; the state register and a 5-bit iteration counter SHALL be internal.
REQ-013 In IDLE, i_con_Start=1 with op 1-4 SHALL be accepted on that edge (E0); operands SHALL be latched as magnitudes (signed ops) or raw values (unsigned ops), along with the result signs; state -> RUN, counter=0.
REQ-014 RUN SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per edge for exactly 32 edges (E1..E32); counter wrap 31->0 SHALL move to FIX.
REQ-015 FIX (edge E33) SHALL apply sign correction, write HI and LO, and return to IDLE.
REQ-016 o_con_Busy SHALL be registered: 1 after E0 through E32, 0 after E33; HI/LO SHALL be valid in the first cycle with Busy=0.
REQ-017 MULT/MULTU: {HI,LO} SHALL equal the full 64-bit signed or unsigned product.
REQ-018 DIV/DIVU: LO SHALL be the quotient and HI the remainder; the signed quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero: HI SHALL equal i_data_A and LO SHALL equal 32'hFFFF_FFFF, with the normal 34-edge latency.
REQ-020 DIV with 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000 and HI=0.
REQ-021 MTHI/MTLO with i_con_Start=1 in IDLE SHALL write i_data_A into HI or LO on that edge, leave the other register unchanged, and never assert Busy.
REQ-022 i_con_Start while Busy=1 SHALL be ignored (no effect on state or HI/LO); the pipeline is responsible for stalling.
REQ-023 i_con_Start with op 0 or 7 SHALL be a no-op.
REQ-024 i_con_Flush=1 SHALL return the state to IDLE and clear Busy on that edge, and SHALL leave HI/LO at their pre-operation values; Flush SHALL take priority over Start and over the FIX writeback in the same cycle.
REQ-025 Flush in IDLE SHALL block a simultaneous Start, including MTHI/MTLO.
REQ-026 HI/LO SHALL hold their values indefinitely between writes; an operand change after E0 SHALL NOT affect the result.

Reset
REQ-027 i_rst=1 SHALL force state IDLE, counter 0, o_con_Busy 0, o_data_Hi 0 and o_data_Lo 0 on the next edge, with priority over Flush and Start.
REQ-028 Reset during RUN or FIX SHALL abort the operation with no HI/LO writeback.

Verification
REQ-029 MULT A=32'hFFFF_FFFE (-2), B=3 -> after 34 edges Busy=0, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; Busy=1 for exactly 33 cycles.
REQ-030 MULTU A=B=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-031 DIV A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU A=7, B=0 -> HI=7, LO=32'hFFFF_FFFF.
REQ-032 MTLO A=32'h1234_5678 in IDLE -> LO=32'h1234_5678 next cycle, HI unchanged, Busy stays 0; the same request while Busy -> ignored.
REQ-033 Start DIV, assert Flush at E10 -> Busy=0 next cycle, HI/LO equal their pre-start values; a new MULT is accepted the following cycle and completes correctly.
REQ-034 Assert i_rst at E20 of a MULTU -> HI=LO=0, Busy=0; a second Start during Busy is ignored and its operands do not alter the result.
